// File: rtl/wb_cmd_sequencer.sv
// Command-queue front end for the Wishbone master: buffers chip-side read/write
// commands, issues them one at a time, and returns read data through a response FIFO.
module wb_cmd_sequencer #(
    parameter int data_wl    = 16,
    parameter int adr_wl     = 16,
    parameter int depth_log2 = 2
) (
    input  logic                  clk,
    input  logic                  a_reset_h,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [adr_wl-1:0]     cmd_addr_i,
    input  logic [data_wl-1:0]    cmd_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [data_wl-1:0]    rsp_data_o,
    output logic [adr_wl-1:0]     mst_addr_o,
    output logic [data_wl-1:0]    mst_data_o,
    output logic                  mst_we_o,
    output logic                  mst_start_o,
    input  logic                  mst_busy_i,
    input  logic                  mst_valid_i,
    input  logic [data_wl-1:0]    mst_data_i,
    output logic [depth_log2:0]   cmd_count_o,
    output logic [15:0]           done_count_o
);

    localparam int DEPTH = 1 << depth_log2;
    localparam int CMD_W = 1 + adr_wl + data_wl;
    localparam logic [depth_log2:0] FULL_CNT = (depth_log2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ISSUE = 3'b010,
        ST_WAIT  = 3'b100
    } state_t;

    state_t state_q, state_d;

    logic [CMD_W-1:0]      cmd_mem [DEPTH];
    logic [depth_log2-1:0] cmd_wr_ptr_q, cmd_wr_ptr_d;
    logic [depth_log2-1:0] cmd_rd_ptr_q, cmd_rd_ptr_d;
    logic [depth_log2:0]   cmd_count_q, cmd_count_d;
    logic                  cmd_push, cmd_pop;

    logic [data_wl-1:0]    rsp_mem [DEPTH];
    logic [depth_log2-1:0] rsp_wr_ptr_q, rsp_wr_ptr_d;
    logic [depth_log2-1:0] rsp_rd_ptr_q, rsp_rd_ptr_d;
    logic [depth_log2:0]   rsp_count_q, rsp_count_d;
    logic                  rsp_push, rsp_pop;

    logic [adr_wl-1:0]     mst_addr_q, mst_addr_d;
    logic [data_wl-1:0]    mst_data_q, mst_data_d;
    logic                  mst_we_q, mst_we_d;
    logic                  mst_start_q, mst_start_d;
    logic [15:0]           done_count_q, done_count_d;

    logic                  head_we;
    logic [adr_wl-1:0]     head_addr;
    logic [data_wl-1:0]    head_data;
    logic                  cmd_empty, rsp_full;

    assign cmd_empty   = (cmd_count_q == '0);
    assign rsp_full    = (rsp_count_q == FULL_CNT);
    assign cmd_ready_o = (cmd_count_q != FULL_CNT);
    assign cmd_push    = cmd_valid_i && cmd_ready_o;
    assign rsp_valid_o = (rsp_count_q != '0);
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;

    assign {head_we, head_addr, head_data} = cmd_mem[cmd_rd_ptr_q];
    // Gate the head word so stale storage never leaks out while the FIFO is empty.
    assign rsp_data_o  = rsp_valid_o ? rsp_mem[rsp_rd_ptr_q] : '0;

    assign mst_addr_o   = mst_addr_q;
    assign mst_data_o   = mst_data_q;
    assign mst_we_o     = mst_we_q;
    assign mst_start_o  = mst_start_q;
    assign cmd_count_o  = cmd_count_q;
    assign done_count_o = done_count_q;

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr_q] <= {cmd_we_i, cmd_addr_i, cmd_data_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_push) begin
            rsp_mem[rsp_wr_ptr_q] <= mst_data_i;
        end
    end

    always_ff @(posedge clk or posedge a_reset_h) begin
        if (a_reset_h) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mst_addr_d   = mst_addr_q;
        mst_data_d   = mst_data_q;
        mst_we_d     = mst_we_q;
        mst_start_d  = 1'b0;
        done_count_d = done_count_q;
        cmd_pop      = 1'b0;
        rsp_push     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // A read may only issue when its response is guaranteed a slot.
                if (!cmd_empty && !mst_busy_i && (head_we || !rsp_full)) begin
                    cmd_pop     = 1'b1;
                    mst_addr_d  = head_addr;
                    mst_data_d  = head_data;
                    mst_we_d    = head_we;
                    mst_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mst_busy_i && mst_valid_i) begin
                    rsp_push     = !mst_we_q;
                    done_count_d = done_count_q + 16'd1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_wr_ptr_d = cmd_push ? cmd_wr_ptr_q + 1'b1 : cmd_wr_ptr_q;
        cmd_rd_ptr_d = cmd_pop  ? cmd_rd_ptr_q + 1'b1 : cmd_rd_ptr_q;
        cmd_count_d  = cmd_count_q;
        case ({cmd_push, cmd_pop})
            2'b10:   cmd_count_d = cmd_count_q + 1'b1;
            2'b01:   cmd_count_d = cmd_count_q - 1'b1;
            default: cmd_count_d = cmd_count_q;
        endcase
    end

    always_comb begin
        rsp_wr_ptr_d = rsp_push ? rsp_wr_ptr_q + 1'b1 : rsp_wr_ptr_q;
        rsp_rd_ptr_d = rsp_pop  ? rsp_rd_ptr_q + 1'b1 : rsp_rd_ptr_q;
        rsp_count_d  = rsp_count_q;
        case ({rsp_push, rsp_pop})
            2'b10:   rsp_count_d = rsp_count_q + 1'b1;
            2'b01:   rsp_count_d = rsp_count_q - 1'b1;
            default: rsp_count_d = rsp_count_q;
        endcase
    end

    always_ff @(posedge clk or posedge a_reset_h) begin
        if (a_reset_h) begin
            cmd_wr_ptr_q <= '0;
            cmd_rd_ptr_q <= '0;
            cmd_count_q  <= '0;
            rsp_wr_ptr_q <= '0;
            rsp_rd_ptr_q <= '0;
            rsp_count_q  <= '0;
            mst_addr_q   <= '0;
            mst_data_q   <= '0;
            mst_we_q     <= 1'b0;
            mst_start_q  <= 1'b0;
            done_count_q <= '0;
        end else begin
            cmd_wr_ptr_q <= cmd_wr_ptr_d;
            cmd_rd_ptr_q <= cmd_rd_ptr_d;
            cmd_count_q  <= cmd_count_d;
            rsp_wr_ptr_q <= rsp_wr_ptr_d;
            rsp_rd_ptr_q <= rsp_rd_ptr_d;
            rsp_count_q  <= rsp_count_d;
            mst_addr_q   <= mst_addr_d;
            mst_data_q   <= mst_data_d;
            mst_we_q     <= mst_we_d;
            mst_start_q  <= mst_start_d;
            done_count_q <= done_count_d;
        end
    end

endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// Bench for wb_cmd_sequencer: behavioural Wishbone master responder plus
// command/response scoreboards checked per scenario.
module tb_wb_cmd_sequencer;

    logic        clk = 1'b0;
    logic        a_reset_h;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [15:0] cmd_addr_i, cmd_data_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [15:0] rsp_data_o;
    logic [15:0] mst_addr_o, mst_data_o;
    logic        mst_we_o, mst_start_o;
    logic        mst_busy_i, mst_valid_i;
    logic [15:0] mst_data_i;
    logic [2:0]  cmd_count_o;
    logic [15:0] done_count_o;

    always #5 clk = ~clk;

    wb_cmd_sequencer #(.data_wl(16), .adr_wl(16), .depth_log2(2)) dut (
        .clk(clk), .a_reset_h(a_reset_h),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .mst_addr_o(mst_addr_o), .mst_data_o(mst_data_o), .mst_we_o(mst_we_o),
        .mst_start_o(mst_start_o), .mst_busy_i(mst_busy_i), .mst_valid_i(mst_valid_i),
        .mst_data_i(mst_data_i), .cmd_count_o(cmd_count_o), .done_count_o(done_count_o)
    );

    // Master model: busy the cycle after start, ack after ack_delay busy cycles,
    // read data is the bitwise inverse of the address. hang suppresses the ack.
    bit          hang;
    int          ack_delay;
    int          m_cnt;
    logic        m_we;
    logic [15:0] m_addr;

    always @(posedge clk or posedge a_reset_h) begin
        if (a_reset_h) begin
            mst_busy_i  <= 1'b0;
            mst_valid_i <= 1'b0;
            mst_data_i  <= 16'h0;
            m_cnt       <= 0;
            m_we        <= 1'b0;
            m_addr      <= 16'h0;
        end else if (mst_start_o) begin
            mst_busy_i  <= 1'b1;
            mst_valid_i <= 1'b0;
            m_cnt       <= 0;
            m_we        <= mst_we_o;
            m_addr      <= mst_addr_o;
        end else if (mst_busy_i) begin
            if (!hang && m_cnt >= ack_delay) begin
                mst_busy_i  <= 1'b0;
                mst_valid_i <= 1'b1;
                mst_data_i  <= m_we ? 16'h0 : ~m_addr;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [32:0] exp_cmd[$], obs_cmd[$];
    logic [15:0] exp_rsp[$], obs_rsp[$];

    // Record what the DUT shows in the current (negedge) sample, then advance one cycle.
    task automatic step();
        if (mst_start_o) obs_cmd.push_back({mst_we_o, mst_addr_o, mst_data_o});
        if (rsp_valid_o && rsp_ready_i) obs_rsp.push_back(rsp_data_o);
        @(negedge clk);
        cyc++;
    endtask

    task automatic offer(input logic we, input logic [15:0] a, input logic [15:0] d);
        int w = 0;
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = a;
        cmd_data_i  = d;
        while (!cmd_ready_o && w < 200) begin
            step();
            w++;
        end
        n_cmp++;
        if (w >= 200) begin
            n_bad++;
            $display("FAIL offer_timeout addr=%h waited=%0d cycles, required acceptance", a, w);
        end else begin
            exp_cmd.push_back({we, a, d});
            if (!we) exp_rsp.push_back(~a);
        end
        step();
        cmd_valid_i = 1'b0;
    endtask

    task automatic apply_reset();
        a_reset_h   = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = 16'h0;
        cmd_data_i  = 16'h0;
        rsp_ready_i = 1'b0;
        hang        = 1'b0;
        ack_delay   = 0;
        @(negedge clk);
        @(negedge clk);
        a_reset_h = 1'b0;
        exp_cmd.delete(); obs_cmd.delete();
        exp_rsp.delete(); obs_rsp.delete();
    endtask

    function automatic logic [70:0] out_vec();
        return {cmd_ready_o, cmd_count_o, rsp_valid_o, rsp_data_o, mst_addr_o,
                mst_data_o, mst_we_o, mst_start_o, done_count_o};
    endfunction

    task automatic test_reset();
        logic [70:0] want;
        want = {1'b1, 70'd0};
        a_reset_h = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_vec() !== want) begin
            n_bad++;
            $display("FAIL reset_during got %h want %h", out_vec(), want);
        end
        apply_reset();
        step();
        n_cmp++;
        if (out_vec() !== want) begin
            n_bad++;
            $display("FAIL reset_after got %h want %h", out_vec(), want);
        end
        $display("test_reset: done");
    endtask

    task automatic test_single_write();
        int w = 0;
        apply_reset();
        rsp_ready_i = 1'b1;
        offer(1'b1, 16'h0010, 16'hBEEF);
        n_cmp++;
        if (mst_start_o !== 1'b0) begin
            n_bad++; $display("FAIL wr_start_cycle1 got %b want 0", mst_start_o);
        end
        step();
        n_cmp++;
        if ({mst_start_o, mst_we_o, mst_addr_o, mst_data_o} !== {1'b1, 1'b1, 16'h0010, 16'hBEEF}) begin
            n_bad++;
            $display("FAIL wr_issue_cycle2 got start=%b we=%b addr=%h data=%h want 1 1 0010 beef",
                     mst_start_o, mst_we_o, mst_addr_o, mst_data_o);
        end
        step();
        n_cmp++;
        if (mst_start_o !== 1'b0) begin
            n_bad++; $display("FAIL wr_start_pulse_width got %b want 0", mst_start_o);
        end
        while (done_count_o !== 16'd1 && w < 50) begin step(); w++; end
        repeat (3) step();
        n_cmp++;
        if (done_count_o !== 16'd1 || rsp_valid_o !== 1'b0 || obs_rsp.size() != 0) begin
            n_bad++;
            $display("FAIL wr_done got done=%0d rsp_valid=%b rsps=%0d want 1 0 0",
                     done_count_o, rsp_valid_o, obs_rsp.size());
        end
        n_cmp++;
        if (obs_cmd.size() !== exp_cmd.size()) begin
            n_bad++; $display("FAIL wr_issue_count got %0d want %0d", obs_cmd.size(), exp_cmd.size());
        end
        while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
            logic [32:0] e, o;
            e = exp_cmd.pop_front(); o = obs_cmd.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL wr_issue got %h want %h", o, e); end
        end
        $display("test_single_write: done_count=%0d", done_count_o);
    endtask

    task automatic test_single_read();
        apply_reset();
        offer(1'b0, ~16'h1234, 16'h0);
        repeat (3) step();
        n_cmp++;
        if (rsp_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL rd_valid_cycle4 got %b want 0", rsp_valid_o);
        end
        step();
        n_cmp++;
        if ({rsp_valid_o, rsp_data_o} !== {1'b1, 16'h1234}) begin
            n_bad++; $display("FAIL rd_rsp_cycle5 got valid=%b data=%h want 1 1234", rsp_valid_o, rsp_data_o);
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        n_cmp++;
        if (rsp_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL rd_valid_after_pop got %b want 0", rsp_valid_o);
        end
        n_cmp++;
        if (obs_rsp.size() !== exp_rsp.size()) begin
            n_bad++; $display("FAIL rd_rsp_count got %0d want %0d", obs_rsp.size(), exp_rsp.size());
        end
        while (exp_rsp.size() > 0 && obs_rsp.size() > 0) begin
            logic [15:0] e, o;
            e = exp_rsp.pop_front(); o = obs_rsp.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL rd_rsp_data got %h want %h", o, e); end
        end
        $display("test_single_read: done");
    endtask

    task automatic test_cmd_full();
        int w = 0;
        apply_reset();
        rsp_ready_i = 1'b1;
        hang = 1'b1;
        for (int i = 0; i < 5; i++) offer(1'b1, 16'h0100 + 16'(i), 16'hC000 + 16'(i));
        n_cmp++;
        if ({cmd_count_o, cmd_ready_o} !== {3'd4, 1'b0} || obs_cmd.size() != 1) begin
            n_bad++;
            $display("FAIL full_after5 got count=%0d ready=%b issued=%0d want 4 0 1",
                     cmd_count_o, cmd_ready_o, obs_cmd.size());
        end
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 16'h0105; cmd_data_i = 16'hC005;
        repeat (5) step();
        n_cmp++;
        if ({cmd_count_o, cmd_ready_o} !== {3'd4, 1'b0}) begin
            n_bad++; $display("FAIL full_hold got count=%0d ready=%b want 4 0", cmd_count_o, cmd_ready_o);
        end
        hang = 1'b0;
        offer(1'b1, 16'h0105, 16'hC005);
        n_cmp++;
        if (cmd_count_o !== 3'd4) begin
            n_bad++; $display("FAIL full_count6 got %0d want 4", cmd_count_o);
        end
        offer(1'b1, 16'h0106, 16'hC006);
        n_cmp++;
        if (cmd_count_o !== 3'd4) begin
            n_bad++; $display("FAIL full_count7 got %0d want 4", cmd_count_o);
        end
        while (done_count_o !== 16'd7 && w < 200) begin step(); w++; end
        n_cmp++;
        if (done_count_o !== 16'd7 || cmd_count_o !== 3'd0) begin
            n_bad++; $display("FAIL full_drain got done=%0d count=%0d want 7 0", done_count_o, cmd_count_o);
        end
        n_cmp++;
        if (obs_cmd.size() !== exp_cmd.size()) begin
            n_bad++; $display("FAIL full_issue_count got %0d want %0d", obs_cmd.size(), exp_cmd.size());
        end
        while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
            logic [32:0] e, o;
            e = exp_cmd.pop_front(); o = obs_cmd.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL full_issue got %h want %h", o, e); end
        end
        $display("test_cmd_full: done_count=%0d", done_count_o);
    endtask

    task automatic test_rsp_backpressure();
        int w = 0;
        apply_reset();
        for (int i = 0; i < 6; i++) offer(1'b0, ~(16'h00A0 + 16'(i)), 16'h0);
        repeat (12) step();
        n_cmp++;
        if (obs_cmd.size() != 4 || mst_start_o !== 1'b0 || cmd_count_o !== 3'd2 || rsp_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_stall got issued=%0d start=%b count=%0d rsp_valid=%b want 4 0 2 1",
                     obs_cmd.size(), mst_start_o, cmd_count_o, rsp_valid_o);
        end
        rsp_ready_i = 1'b1;
        while (obs_rsp.size() < 6 && w < 200) begin step(); w++; end
        rsp_ready_i = 1'b0;
        n_cmp++;
        if (obs_rsp.size() !== exp_rsp.size()) begin
            n_bad++; $display("FAIL bp_rsp_count got %0d want %0d", obs_rsp.size(), exp_rsp.size());
        end
        while (exp_rsp.size() > 0 && obs_rsp.size() > 0) begin
            logic [15:0] e, o;
            e = exp_rsp.pop_front(); o = obs_rsp.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL bp_rsp_data got %h want %h", o, e); end
        end
        n_cmp++;
        if (obs_cmd.size() !== exp_cmd.size()) begin
            n_bad++; $display("FAIL bp_issue_count got %0d want %0d", obs_cmd.size(), exp_cmd.size());
        end
        $display("test_rsp_backpressure: done_count=%0d", done_count_o);
    endtask

    task automatic test_mixed_order();
        int w = 0;
        apply_reset();
        rsp_ready_i = 1'b1;
        ack_delay = 2;
        offer(1'b1, 16'h0040, 16'h5555);
        offer(1'b0, ~16'h0011, 16'h0);
        offer(1'b1, 16'h0041, 16'hAAAA);
        offer(1'b0, ~16'h0022, 16'h0);
        while (done_count_o !== 16'd4 && w < 200) begin step(); w++; end
        repeat (3) step();
        n_cmp++;
        if (done_count_o !== 16'd4) begin
            n_bad++; $display("FAIL mix_done got %0d want 4", done_count_o);
        end
        n_cmp++;
        if (obs_rsp.size() !== 2) begin
            n_bad++; $display("FAIL mix_rsp_count got %0d want 2", obs_rsp.size());
        end
        while (exp_rsp.size() > 0 && obs_rsp.size() > 0) begin
            logic [15:0] e, o;
            e = exp_rsp.pop_front(); o = obs_rsp.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL mix_rsp_data got %h want %h", o, e); end
        end
        while (exp_cmd.size() > 0 && obs_cmd.size() > 0) begin
            logic [32:0] e, o;
            e = exp_cmd.pop_front(); o = obs_cmd.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL mix_issue got %h want %h", o, e); end
        end
        $display("test_mixed_order: done_count=%0d", done_count_o);
    endtask

    task automatic test_reset_mid();
        logic [70:0] want;
        want = {1'b1, 70'd0};
        apply_reset();
        rsp_ready_i = 1'b1;
        hang = 1'b1;
        offer(1'b0, ~16'h0077, 16'h0);
        offer(1'b1, 16'h0050, 16'h1111);
        offer(1'b1, 16'h0051, 16'h2222);
        n_cmp++;
        if (cmd_count_o !== 3'd2 || obs_cmd.size() != 1) begin
            n_bad++; $display("FAIL rmid_pre got count=%0d issued=%0d want 2 1", cmd_count_o, obs_cmd.size());
        end
        #2;
        a_reset_h = 1'b1;
        #1;
        n_cmp++;
        if (out_vec() !== want) begin
            n_bad++; $display("FAIL rmid_async got %h want %h", out_vec(), want);
        end
        @(negedge clk);
        a_reset_h = 1'b0;
        hang = 1'b0;
        obs_cmd.delete(); obs_rsp.delete();
        repeat (10) step();
        n_cmp++;
        if (obs_cmd.size() != 0 || obs_rsp.size() != 0 || out_vec() !== want) begin
            n_bad++;
            $display("FAIL rmid_after got starts=%0d rsps=%0d outs=%h want 0 0 %h",
                     obs_cmd.size(), obs_rsp.size(), out_vec(), want);
        end
        $display("test_reset_mid: done");
    endtask

    initial begin
        a_reset_h   = 1'b1;
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        test_reset();
        test_single_write();
        test_single_read();
        test_cmd_full();
        test_rsp_backpressure();
        test_mixed_order();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_cmd_sequencer.md
Name: wb_cmd_sequencer

Overview:
- Command-queue front end that sits directly upstream of the Wishbone master.
- Buffers read/write commands from chip-side logic in a FIFO.
- Issues them one at a time on the master's addr/data/we/start interface and tracks each to completion via busy/valid.
- Returns read data through a backpressured response FIFO, so chip logic never handles the master handshake directly.

Parameters:
- data_wl, 16, data width; matches the master.
- adr_wl, 16, address width; matches the master.
- depth_log2, 2, log2 of the entry count of both the command FIFO and the response FIFO (default depth 4).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- a_reset_h  in  1  asynchronous reset, active-high.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command FIFO not full.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  adr_wl  command address.
- cmd_data_i  in  data_wl  write data; ignored for reads.
- rsp_valid_o  out  1  response FIFO not empty.
- rsp_ready_i  in  1  consumer takes the head response.
- rsp_data_o  out  data_wl  head read data.
- mst_addr_o  out  adr_wl  to master addr_i.
- mst_data_o  out  data_wl  to master data_i.
- mst_we_o  out  1  to master we_i.
- mst_start_o  out  1  to master start_i; one-cycle pulse.
- mst_busy_i  in  1  from master busy_o.
- mst_valid_i  in  1  from master valid_o.
- mst_data_i  in  data_wl  from master data_o.
- cmd_count_o  out  depth_log2+1  command FIFO occupancy.
- done_count_o  out  16  completed transactions; wraps 0xFFFF→0.

Behaviour:
- Reset (asynchronous; also mid-transaction):
  - Both FIFOs empty; FSM returns to IDLE.
  - All outputs 0 except cmd_ready_o = 1.
  - Any in-flight transaction is abandoned; its response is never pushed.
- Command FIFO:
  - Push on cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = (cmd_count_o != 2^depth_log2).
  - Push and pop in the same cycle leaves the count unchanged.
  - No bypass: an entry is visible to the FSM one cycle after its push.
  - Pointers wrap modulo the depth.
- Response FIFO:
  - Push only on read completion; pop on rsp_valid_o && rsp_ready_i.
  - rsp_data_o shows the head entry combinationally from storage.
  - Simultaneous push and pop when full is impossible, because reads are gated at issue (see IDLE).
- FSM, one-hot, states IDLE / ISSUE / WAIT:
  - IDLE:
    - Leave IDLE when the command FIFO is not empty and mst_busy_i == 0.
    - Additionally, for a read at the head, the response FIFO must not be full.
    - On that edge: register mst_addr_o/mst_data_o/mst_we_o from the FIFO head, pop the FIFO, set mst_start_o <= 1, go to ISSUE.
    - Otherwise mst_start_o stays 0.
  - ISSUE:
    - mst_start_o is high for exactly this cycle.
    - Next edge: mst_start_o <= 0, go to WAIT.
  - WAIT:
    - Completion condition: mst_busy_i == 0 && mst_valid_i == 1.
    - The master raises busy the cycle after start, so the first WAIT cycle always sees busy = 1; a stale valid from the previous transaction is already cleared.
    - On completion: if mst_we_o == 0, push mst_data_i into the response FIFO; increment done_count_o; go to IDLE.
    - No timeout: WAIT holds indefinitely.
  - The default (illegal) state goes to IDLE.
- mst_addr_o/mst_data_o/mst_we_o hold their values until the next issue.
- Latency (empty queue, idle master, slave acks on the first master-busy cycle):
  - cmd handshake at edge 0 → mst_start_o high in cycle 2.
  - Completion seen in cycle 4 → rsp_valid_o high in cycle 5.
  - Back-to-back commands: minimum 4 cycles between consecutive start pulses (ISSUE, WAIT ≥ 2, IDLE).
- Writes produce no response. Read responses return strictly in command order.

Test Plan:
- Single write: cmd we=1, addr=0x0010, data=0xBEEF → mst_start_o one-cycle pulse in cycle 2 with mst_addr_o=0x0010, mst_data_o=0xBEEF, mst_we_o=1; done_count_o=1; rsp_valid_o stays 0.
- Single read: slave returns 0x1234, ack in the first busy cycle → rsp_valid_o=1 in cycle 5 with rsp_data_o=0x1234; drops the cycle after rsp_ready_i.
- Command full: slave never acks; push 5 commands back-to-back → 1 issued, the remaining 4 fill the FIFO, cmd_count_o=4, cmd_ready_o=0; the 6th offer is held off until an issue pops an entry; with pushes continuing, count stays at 4 and no command is lost or duplicated.
- Response backpressure: rsp_ready_i=0, 6 reads queued with data 0xA0..0xA5 → exactly 4 issued; the 5th holds in IDLE with mst_start_o=0 until a pop; all 6 are then delivered in order.
- Mixed order: W, R(0x11), W, R(0x22) → responses 0x11 then 0x22 only; done_count_o=4.
- Reset mid-transaction: assert a_reset_h during WAIT with 2 commands queued → all outputs at reset values immediately; after release cmd_count_o=0, no start pulse, no response pushed.
